// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: two requester channels (operands,
// opcode, valid/ready) and one tagged response channel (valid/ready).
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_A;
    logic [DATA_WIDTH-1:0] req0_B;
    logic [2:0]            req0_ALUop;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_A;
    logic [DATA_WIDTH-1:0] req1_B;
    logic [2:0]            req1_ALUop;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_id;
    logic [DATA_WIDTH-1:0] resp_Result;
    logic                  resp_Overflow;
    logic                  resp_CarryOut;
    logic                  resp_Zero;

    modport master (
        output req0_valid, req0_A, req0_B, req0_ALUop,
        input  req0_ready,
        output req1_valid, req1_A, req1_B, req1_ALUop,
        input  req1_ready,
        output resp_ready,
        input  resp_valid, resp_id, resp_Result,
        input  resp_Overflow, resp_CarryOut, resp_Zero
    );

    modport slave (
        input  req0_valid, req0_A, req0_B, req0_ALUop,
        output req0_ready,
        input  req1_valid, req1_A, req1_B, req1_ALUop,
        output req1_ready,
        input  resp_ready,
        output resp_valid, resp_id, resp_Result,
        output resp_Overflow, resp_CarryOut, resp_Zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters, with a one-entry registered response buffer tagged by requester.
// Optional feature macro: ALU_ARB_FLAGS_EN (registers Overflow/CarryOut/Zero;
// when undefined those outputs are tied to 0).
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    buf_state_t            state_q, state_d;
    logic                  resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  last_grant_q, last_grant_d;

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic                  accept;
    logic                  grant_valid;
    logic                  grant_id;

    logic [DATA_WIDTH-1:0] alu_a, alu_b, b_eff, alu_result;
    logic [2:0]            alu_op;
    logic [DATA_WIDTH:0]   sum;
    logic                  alu_ovf, alu_carry, alu_zero;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept && grant_valid && (grant_id == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    // Round-robin grant: a tie goes to whichever requester did not win last.
    always_comb begin
        accept      = (state_q == BUF_EMPTY) || bus.resp_ready;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (accept) begin
            if (req_valid == 2'b11) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (req_valid[0]) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req_valid[1]) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Operand mux (defaults to requester 0) feeding the shared ALU.
    always_comb begin
        alu_a      = grant_id ? bus.req1_A     : bus.req0_A;
        alu_b      = grant_id ? bus.req1_B     : bus.req0_B;
        alu_op     = grant_id ? bus.req1_ALUop : bus.req0_ALUop;
        b_eff      = (alu_op == 3'b110) ? ~alu_b : alu_b;
        sum        = {1'b0, alu_a} + {1'b0, b_eff}
                   + {{DATA_WIDTH{1'b0}}, (alu_op == 3'b110)};
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010, 3'b110: begin
                // SUB is A + ~B + 1, so CarryOut=1 means no borrow.
                alu_result = sum[MSB:0];
                alu_carry  = sum[DATA_WIDTH];
                alu_ovf    = (alu_a[MSB] == b_eff[MSB]) && (alu_result[MSB] != alu_a[MSB]);
            end
            3'b111: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Buffer next state: a transfer overwrites (even while draining), a bare drain empties.
    always_comb begin
        state_d      = state_q;
        resp_id_d    = resp_id_q;
        result_d     = result_q;
        last_grant_d = last_grant_q;
        if (grant_valid) begin
            state_d      = BUF_FULL;
            resp_id_d    = grant_id;
            result_d     = alu_result;
            last_grant_d = grant_id;
        end else if ((state_q == BUF_FULL) && bus.resp_ready) begin
            state_d = BUF_EMPTY;
        end
    end

    // Buffer and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BUF_EMPTY;
            resp_id_q    <= 1'b0;
            result_q     <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            resp_id_q    <= resp_id_d;
            result_q     <= result_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.resp_valid  = (state_q == BUF_FULL);
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_Result = result_q;

`ifdef ALU_ARB_FLAGS_EN
    logic ovf_q, ovf_d, carry_q, carry_d, zero_q, zero_d;

    // Flags follow the same capture rule as Result.
    always_comb begin
        ovf_d   = ovf_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (grant_valid) begin
            ovf_d   = alu_ovf;
            carry_d = alu_carry;
            zero_d  = alu_zero;
        end
    end

    // Flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.resp_Overflow = ovf_q;
    assign bus.resp_CarryOut = carry_q;
    assign bus.resp_Zero     = zero_q;
`else
    logic unused_flags;
    assign unused_flags      = ^{alu_ovf, alu_carry, alu_zero};
    assign bus.resp_Overflow = 1'b0;
    assign bus.resp_CarryOut = 1'b0;
    assign bus.resp_Zero     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level reference model.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit          m_valid;
    bit          m_id;
    bit          m_last;
    logic [31:0] m_res;
    logic        m_o, m_c, m_z;

    // ALU behaviour from the arithmetic definitions.
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op, output logic [31:0] r,
                                    output logic o, output logic c, output logic z);
        longint ua, ub, sa, sb, t;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; o = 1'b0; c = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                t = ua + ub; r = t[31:0]; c = (ua + ub) > 64'hFFFF_FFFF;
                t = sa + sb; o = (longint'($signed(r)) != t);
            end
            3'b110: begin
                t = ua - ub; r = t[31:0]; c = (ua >= ub);
                t = sa - sb; o = (longint'($signed(r)) != t);
            end
            3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        z = (r == 32'd0);
`ifndef ALU_ARB_FLAGS_EN
        o = 1'b0; c = 1'b0; z = 1'b0;
`endif
    endfunction

    // Expected grant this cycle: -1 none, else requester index.
    function automatic int exp_grant();
        if (m_valid && !bus.resp_ready) return -1;
        if (bus.req0_valid && bus.req1_valid) return m_last ? 0 : 1;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    // Advance one clock edge and update the model from the inputs seen at it.
    task automatic tick();
        int          g;
        logic [31:0] r;
        logic        o, c, z;
        bit          rr;
        g  = exp_grant();
        rr = bus.resp_ready;
        if (g == 0) ref_alu(bus.req0_A, bus.req0_B, bus.req0_ALUop, r, o, c, z);
        else        ref_alu(bus.req1_A, bus.req1_B, bus.req1_ALUop, r, o, c, z);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_id = 0; m_last = 1; m_res = '0;
            m_o = 0; m_c = 0; m_z = 0;
        end else if (g >= 0) begin
            m_valid = 1; m_id = g[0]; m_last = g[0]; m_res = r;
            m_o = o; m_c = c; m_z = z;
        end else if (m_valid && rr) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic drive(input int which, input bit v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
        if (which == 0) begin
            bus.req0_valid = v; bus.req0_A = a; bus.req0_B = b; bus.req0_ALUop = op;
        end else begin
            bus.req1_valid = v; bus.req1_A = a; bus.req1_B = b; bus.req1_ALUop = op;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++;
        if (bus.resp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.resp_valid); else n_pass++;
        n_total++;
        if ({bus.resp_id, bus.resp_Result} !== 33'd0) $display("FAIL reset_data got %h want 0", {bus.resp_id, bus.resp_Result}); else n_pass++;
        n_total++;
        if ({bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero} !== 3'b000)
            $display("FAIL reset_flags got %b want 000", {bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}); else n_pass++;
        n_total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b00) $display("FAIL reset_ready got %b want 00", {bus.req1_ready, bus.req0_ready}); else n_pass++;
        $display("reset: resp_valid=%b", bus.resp_valid);
    endtask

    task automatic test_single();
        drive(0, 1, 32'd5, 32'd7, 3'b010);
        bus.resp_ready = 1'b1;
        #1;
        n_total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) $display("FAIL single_ready got %b want 01", {bus.req1_ready, bus.req0_ready}); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0);
        n_total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_Result} !== {1'b1, 1'b0, 32'd12})
            $display("FAIL single_resp got v=%b id=%b r=%0d want v=1 id=0 r=12", bus.resp_valid, bus.resp_id, bus.resp_Result); else n_pass++;
        n_total++;
        if ({bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero} !== {m_o, m_c, m_z})
            $display("FAIL single_flags got %b want %b", {bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}, {m_o, m_c, m_z}); else n_pass++;
        $display("single: 5+7 -> id=%b result=%0d", bus.resp_id, bus.resp_Result);
        tick();
        n_total++;
        if (bus.resp_valid !== 1'b0) $display("FAIL single_drain got %b want 0", bus.resp_valid); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [31:0] want;
        do_reset();
        drive(0, 1, 32'd3, 32'd3, 3'b110);
        drive(1, 1, 32'h7FFF_FFFF, 32'd1, 3'b010);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_total++;
            if ({bus.req1_ready, bus.req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL alt_ready[%0d] got %b", i, {bus.req1_ready, bus.req0_ready}); else n_pass++;
            tick();
            want = (i % 2 == 0) ? 32'd0 : 32'h8000_0000;
            n_total++;
            if ({bus.resp_valid, bus.resp_id, bus.resp_Result} !== {1'b1, 1'(i % 2), want})
                $display("FAIL alt_resp[%0d] got v=%b id=%b r=%h want v=1 id=%0d r=%h", i, bus.resp_valid, bus.resp_id, bus.resp_Result, i % 2, want); else n_pass++;
            n_total++;
            if ({bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero} !== {m_o, m_c, m_z})
                $display("FAIL alt_flags[%0d] got %b want %b", i, {bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}, {m_o, m_c, m_z}); else n_pass++;
`ifdef ALU_ARB_FLAGS_EN
            n_total++;
            if ((i % 2 == 0) ? (bus.resp_Zero !== 1'b1) : (bus.resp_Overflow !== 1'b1))
                $display("FAIL alt_keyflag[%0d] got ovf=%b zero=%b", i, bus.resp_Overflow, bus.resp_Zero); else n_pass++;
`else
            n_total++;
            if ({bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero} !== 3'b000)
                $display("FAIL alt_flags_off[%0d] got %b want 000", i, {bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}); else n_pass++;
`endif
            $display("alternate[%0d]: id=%b result=%h", i, bus.resp_id, bus.resp_Result);
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] snap;
        int g;
        drive(0, 1, $urandom, $urandom, 3'b001);
        drive(1, 1, $urandom, $urandom, 3'b000);
        bus.resp_ready = 1'b0;
        snap = {bus.resp_valid, bus.resp_id, bus.resp_Result, bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero};
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if ({bus.req1_ready, bus.req0_ready} !== 2'b00) $display("FAIL bp_ready[%0d] got %b want 00", i, {bus.req1_ready, bus.req0_ready}); else n_pass++;
            tick();
            n_total++;
            if ({bus.resp_valid, bus.resp_id, bus.resp_Result, bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero} !== snap)
                $display("FAIL bp_hold[%0d] got %h want %h", i, {bus.resp_valid, bus.resp_id, bus.resp_Result, bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}, snap); else n_pass++;
            $display("backpressure[%0d]: held id=%b result=%h", i, bus.resp_id, bus.resp_Result);
        end
        bus.resp_ready = 1'b1;
        #1;
        g = exp_grant();
        n_total++;
        if ({bus.req1_ready, bus.req0_ready} !== {g == 1, g == 0}) $display("FAIL bp_release_ready got %b grant %0d", {bus.req1_ready, bus.req0_ready}, g); else n_pass++;
        tick();
        n_total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_Result} !== {1'b1, m_id, m_res})
            $display("FAIL bp_refill got v=%b id=%b r=%h want v=1 id=%b r=%h", bus.resp_valid, bus.resp_id, bus.resp_Result, m_id, m_res); else n_pass++;
        $display("backpressure release: id=%b result=%h", bus.resp_id, bus.resp_Result);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_slt();
        drive(1, 1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        bus.resp_ready = 1'b1;
        #1;
        n_total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) $display("FAIL slt_ready got %b want 10", {bus.req1_ready, bus.req0_ready}); else n_pass++;
        tick();
        n_total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_Result} !== {1'b1, 1'b1, 32'd1})
            $display("FAIL slt_neg got id=%b r=%h want id=1 r=1", bus.resp_id, bus.resp_Result); else n_pass++;
        $display("slt: -1<1 -> %0d", bus.resp_Result);
        drive(1, 1, 32'd1, 32'hFFFF_FFFF, 3'b111);
        tick();
        n_total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_Result} !== {1'b1, 1'b1, 32'd0})
            $display("FAIL slt_pos got id=%b r=%h want id=1 r=0", bus.resp_id, bus.resp_Result); else n_pass++;
        $display("slt: 1<-1 -> %0d", bus.resp_Result);
        drive(1, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_full();
        drive(0, 1, $urandom, $urandom, 3'b010);
        bus.resp_ready = 1'b0;
        tick();
        n_total++;
        if (bus.resp_valid !== 1'b1) $display("FAIL rstfull_fill got %b want 1", bus.resp_valid); else n_pass++;
        drive(1, 1, $urandom, $urandom, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++;
        if ({bus.resp_valid, bus.resp_Result} !== 33'd0) $display("FAIL rstfull_clear got v=%b r=%h want 0", bus.resp_valid, bus.resp_Result); else n_pass++;
        bus.resp_ready = 1'b1;
        #1;
        n_total++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) $display("FAIL rstfull_tie got %b want 01", {bus.req1_ready, bus.req0_ready}); else n_pass++;
        tick();
        n_total++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_Result} !== {1'b1, 1'b0, m_res})
            $display("FAIL rstfull_resp got v=%b id=%b r=%h want v=1 id=0 r=%h", bus.resp_valid, bus.resp_id, bus.resp_Result, m_res); else n_pass++;
        $display("reset while full: tie went to id=%b", bus.resp_id);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();
    endtask

    function automatic logic [31:0] pick_operand(input logic [31:0] other);
        logic [31:0] corners [4];
        corners = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return $urandom_range(0, 15);
            2: return corners[$urandom_range(0, 3)];
            default: return other;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0]  ops [8];
        logic [31:0] a;
        int          g;
        int          last_g = -1;
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (((r == 0) ? !bus.req0_valid : !bus.req1_valid) || last_g == r) begin
                    a = pick_operand($urandom);
                    drive(r, $urandom_range(0, 3) != 0, a, pick_operand(a), ops[$urandom_range(0, 7)]);
                end
            end
            bus.resp_ready = $urandom_range(0, 3) != 0;
            #1;
            g = exp_grant();
            n_total++;
            if ({bus.req1_ready, bus.req0_ready} !== {g == 1, g == 0})
                $display("FAIL rand_ready[%0d] got %b grant %0d", i, {bus.req1_ready, bus.req0_ready}, g); else n_pass++;
            tick();
            last_g = g;
            n_total++;
            if (bus.resp_valid !== m_valid) $display("FAIL rand_valid[%0d] got %b want %b", i, bus.resp_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_total++;
                if ({bus.resp_id, bus.resp_Result, bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero} !== {m_id, m_res, m_o, m_c, m_z})
                    $display("FAIL rand_resp[%0d] got id=%b r=%h f=%b want id=%b r=%h f=%b", i, bus.resp_id, bus.resp_Result,
                             {bus.resp_Overflow, bus.resp_CarryOut, bus.resp_Zero}, m_id, m_res, {m_o, m_c, m_z}); else n_pass++;
            end
            $display("random[%0d]: grant=%0d resp_valid=%b id=%b result=%h", i, g, bus.resp_valid, bus.resp_id, bus.resp_Result);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_slt();
        test_reset_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
